// File: rtl/rps_match_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rps_match_sequencer
// Purpose  : Best-of-N round sequencer for Rock-Paper-Scissors (arm, freeze,
//            classify, show, score). Optional pick timeout: RPS_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rps_match_sequencer #(
  parameter int unsigned WINS_TO_MATCH  = 3,
  parameter int unsigned SCORE_W        = 4,
  parameter int unsigned ROUND_W        = 6,
  parameter int unsigned SHOW_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               confirm,
  input  logic [1:0]         player_choice,
  input  logic [1:0]         computer_choice,
  input  logic               player_win,
  output logic               stop_signal,
  output logic               clear_choice,
  output logic               win_led,
  output logic               lose_led,
  output logic               tie_led,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] computer_score,
  output logic [ROUND_W-1:0] round_count,
  output logic               match_done,
  output logic               timeout_flag,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PICK = 3'd1,
    LOCK      = 3'd2,
    EVAL      = 3'd3,
    SHOW      = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam int unsigned SHOW_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [SCORE_W-1:0] c_wins_target = SCORE_W'(WINS_TO_MATCH);
  localparam logic [SHOW_W-1:0]  c_show_load   = SHOW_W'(SHOW_CYCLES - 1);

  if ((WINS_TO_MATCH < 1) || (WINS_TO_MATCH > (2**SCORE_W) - 1) ||
      (SHOW_CYCLES < 1) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("rps_match_sequencer: illegal parameter combination");
  end

  state_t             r_state;
  state_t             w_next;
  logic [SHOW_W-1:0]  r_show_cnt;
  logic [SCORE_W-1:0] r_pscore;
  logic [SCORE_W-1:0] r_cscore;
  logic [ROUND_W-1:0] r_rounds;
  logic               r_stop;
  logic               r_clear;
  logic               r_win;
  logic               r_lose;
  logic               r_tie;
  logic               r_done;

  logic w_valid_pick;
  logic w_expired;
  logic w_forfeit;
  logic w_tie_raw;
  logic w_pwin;
  logic w_cwin;
  logic w_tie;
  logic w_match_won;
  logic w_new_match;
  logic w_enter_wait;
  logic w_stop_nxt;
  logic w_win_nxt;
  logic w_lose_nxt;
  logic w_tie_nxt;

  assign w_valid_pick = confirm && (player_choice != 2'b00);
  assign w_match_won  = (r_pscore == c_wins_target) || (r_cscore == c_wins_target);
  assign w_new_match  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_enter_wait = (w_next == WAIT_PICK) && (r_state != WAIT_PICK);

  // A frozen computer choice of 00 never resolved, so the round is void.
  assign w_tie_raw = (player_choice == computer_choice) || (computer_choice == 2'b00);
  assign w_pwin    = !w_forfeit && !w_tie_raw && player_win;
  assign w_cwin    = w_forfeit || (!w_tie_raw && !player_win);
  assign w_tie     = !w_forfeit && w_tie_raw;

`ifdef RPS_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] c_to_load = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_forfeit;
  logic            r_timeout;

  assign w_expired = (r_state == WAIT_PICK) && (r_to_cnt == '0);
  assign w_forfeit = r_forfeit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt  <= '0;
      r_forfeit <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_enter_wait) begin
        r_to_cnt <= c_to_load;
      end else if ((r_state == WAIT_PICK) && (r_to_cnt != '0)) begin
        r_to_cnt <= r_to_cnt - 1'b1;
      end
      // A valid confirm on the expiry cycle wins over the forfeit.
      if ((r_state == WAIT_PICK) && (w_next == LOCK)) begin
        r_forfeit <= !w_valid_pick;
      end
      if (w_new_match) begin
        r_timeout <= 1'b0;
      end else if (r_state == EVAL) begin
        r_timeout <= r_forfeit;
      end
    end
  end

  assign timeout_flag = r_timeout;
`else
  assign w_expired    = 1'b0;
  assign w_forfeit    = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_stop_nxt = 1'b0;
    w_win_nxt  = 1'b0;
    w_lose_nxt = 1'b0;
    w_tie_nxt  = 1'b0;

    case (r_state)
      IDLE:      if (start) w_next = WAIT_PICK;
      WAIT_PICK: if (w_valid_pick || w_expired) w_next = LOCK;
      LOCK:      w_next = EVAL;
      EVAL:      w_next = SHOW;
      SHOW: begin
        if (r_show_cnt == '0) begin
          w_next = w_match_won ? DONE : WAIT_PICK;
        end
      end
      DONE:      if (start) w_next = WAIT_PICK;
      default:   w_next = IDLE;
    endcase

    case (w_next)
      LOCK, EVAL: w_stop_nxt = 1'b1;
      SHOW: begin
        w_stop_nxt = 1'b1;
        if (r_state == EVAL) begin
          w_win_nxt  = w_pwin;
          w_lose_nxt = w_cwin;
          w_tie_nxt  = w_tie;
        end else begin
          w_win_nxt  = r_win;
          w_lose_nxt = r_lose;
          w_tie_nxt  = r_tie;
        end
      end
      DONE: begin
        w_stop_nxt = 1'b1;
        w_win_nxt  = (r_pscore == c_wins_target);
        w_lose_nxt = (r_pscore != c_wins_target);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stop  <= 1'b0;
      r_clear <= 1'b0;
      r_win   <= 1'b0;
      r_lose  <= 1'b0;
      r_tie   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_stop  <= w_stop_nxt;
      r_clear <= w_enter_wait;
      r_win   <= w_win_nxt;
      r_lose  <= w_lose_nxt;
      r_tie   <= w_tie_nxt;
      r_done  <= (w_next == DONE);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_show_cnt <= '0;
    end else if (r_state == EVAL) begin
      r_show_cnt <= c_show_load;
    end else if ((r_state == SHOW) && (r_show_cnt != '0)) begin
      r_show_cnt <= r_show_cnt - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pscore <= '0;
      r_cscore <= '0;
      r_rounds <= '0;
    end else if (w_new_match) begin
      r_pscore <= '0;
      r_cscore <= '0;
      r_rounds <= '0;
    end else if (r_state == EVAL) begin
      if (w_pwin && (r_pscore != c_wins_target)) r_pscore <= r_pscore + 1'b1;
      if (w_cwin && (r_cscore != c_wins_target)) r_cscore <= r_cscore + 1'b1;
      if (r_rounds != '1) r_rounds <= r_rounds + 1'b1;
    end
  end

  assign stop_signal    = r_stop;
  assign clear_choice   = r_clear;
  assign win_led        = r_win;
  assign lose_led       = r_lose;
  assign tie_led        = r_tie;
  assign player_score   = r_pscore;
  assign computer_score = r_cscore;
  assign round_count    = r_rounds;
  assign match_done     = r_done;
  assign state          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_rps_match_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rps_match_sequencer
// Purpose  : Directed self-checking bench for rps_match_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rps_match_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       confirm = 1'b0;
  logic [1:0] player_choice = 2'b00;
  logic [1:0] computer_choice = 2'b00;
  logic       player_win = 1'b0;
  logic       stop_signal, clear_choice, win_led, lose_led, tie_led;
  logic [3:0] player_score, computer_score;
  logic [5:0] round_count;
  logic       match_done, timeout_flag;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef RPS_TIMEOUT_EN
  localparam int INV_HOLD = 5;
`else
  localparam int INV_HOLD = 10;
`endif

  rps_match_sequencer #(
    .WINS_TO_MATCH  (3),
    .SCORE_W        (4),
    .ROUND_W        (6),
    .SHOW_CYCLES    (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .confirm         (confirm),
    .player_choice   (player_choice),
    .computer_choice (computer_choice),
    .player_win      (player_win),
    .stop_signal     (stop_signal),
    .clear_choice    (clear_choice),
    .win_led         (win_led),
    .lose_led        (lose_led),
    .tie_led         (tie_led),
    .player_score    (player_score),
    .computer_score  (computer_score),
    .round_count     (round_count),
    .match_done      (match_done),
    .timeout_flag    (timeout_flag),
    .state           (state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [23:0] all_outs();
    return {stop_signal, clear_choice, win_led, lose_led, tie_led, player_score,
            computer_score, round_count, match_done, timeout_flag, state};
  endfunction

  // Plays one confirmed round from WAIT_PICK and reports what was observed.
  task automatic run_round(input logic [1:0] pc, input logic [1:0] cc, input logic pw,
                           output logic [2:0] leds, output logic [13:0] scores,
                           output int show_len, output logic [2:0] st_after,
                           output logic clr_after, output logic stop_lock);
    player_choice = pc; computer_choice = cc; player_win = pw; confirm = 1'b1;
    tick();
    stop_lock = stop_signal && (state == 3'd2);
    confirm = 1'b0;
    tick();
    tick();
    leds   = {win_led, lose_led, tie_led};
    scores = {player_score, computer_score, round_count};
    show_len = 0;
    while (state == 3'd4 && show_len < 100) begin
      show_len++;
      tick();
    end
    st_after  = state;
    clr_after = clear_choice;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    n_checks++;
    if (all_outs() !== 24'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", all_outs(), 24'h0);
    end
    reset_n = 1'b1;
    tick(); tick();
    n_checks++;
    if (state !== 3'd0) begin
      n_fail++; $display("FAIL reset_idle: got %0d expected 0", state);
    end
  endtask

  task automatic test_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({state, clear_choice, stop_signal} !== {3'd1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL start_enter: got st=%0d clr=%b stop=%b expected st=1 clr=1 stop=0",
                         state, clear_choice, stop_signal);
    end
    tick();
    n_checks++;
    if (clear_choice !== 1'b0) begin
      n_fail++; $display("FAIL start_clear_pulse: got %b expected 0", clear_choice);
    end
  endtask

  task automatic test_first_round();
    logic [2:0] leds, st; logic [13:0] sc; int len; logic clr, stp;
    run_round(2'b10, 2'b01, 1'b1, leds, sc, len, st, clr, stp);
    n_checks++;
    if (stp !== 1'b1) begin
      n_fail++; $display("FAIL lock_stop: got %b expected 1", stp);
    end
    n_checks++;
    if (leds !== 3'b100) begin
      n_fail++; $display("FAIL first_leds: got %b expected 100", leds);
    end
    n_checks++;
    if (sc !== {4'd1, 4'd0, 6'd1}) begin
      n_fail++; $display("FAIL first_scores: got %h expected %h", sc, {4'd1, 4'd0, 6'd1});
    end
    n_checks++;
    if (len !== 16) begin
      n_fail++; $display("FAIL show_dwell: got %0d expected 16", len);
    end
    n_checks++;
    if ({st, clr} !== {3'd1, 1'b1}) begin
      n_fail++; $display("FAIL return_wait: got st=%0d clr=%b expected st=1 clr=1", st, clr);
    end
    tick();
    n_checks++;
    if ({clear_choice, stop_signal, win_led} !== 3'b000) begin
      n_fail++; $display("FAIL wait_quiet: got %b expected 000",
                         {clear_choice, stop_signal, win_led});
    end
  endtask

  task automatic test_match();
    logic [1:0]  pcs [0:3];
    logic [1:0]  ccs [0:3];
    logic        pws [0:3];
    logic [2:0]  eleds [0:3];
    logic [13:0] esc [0:3];
    logic [2:0]  leds, st; logic [13:0] sc; int len; logic clr, stp;
    pcs   = '{2'b01, 2'b01, 2'b11, 2'b10};
    ccs   = '{2'b10, 2'b11, 2'b01, 2'b01};
    pws   = '{1'b0, 1'b1, 1'b0, 1'b1};
    eleds = '{3'b010, 3'b100, 3'b010, 3'b100};
    esc   = '{{4'd1, 4'd1, 6'd2}, {4'd2, 4'd1, 6'd3}, {4'd2, 4'd2, 6'd4}, {4'd3, 4'd2, 6'd5}};
    for (int i = 0; i < 4; i++) begin
      run_round(pcs[i], ccs[i], pws[i], leds, sc, len, st, clr, stp);
      n_checks++;
      if ({leds, sc} !== {eleds[i], esc[i]}) begin
        n_fail++; $display("FAIL match_round%0d: got leds=%b sc=%h expected leds=%b sc=%h",
                           i, leds, sc, eleds[i], esc[i]);
      end
    end
    n_checks++;
    if (st !== 3'd5) begin
      n_fail++; $display("FAIL match_done_state: got %0d expected 5", st);
    end
    player_choice = 2'b01; computer_choice = 2'b10; confirm = 1'b1;
    repeat (3) tick();
    confirm = 1'b0;
    n_checks++;
    if ({state, match_done, win_led, lose_led, tie_led, stop_signal} !== {3'd5, 5'b11001}) begin
      n_fail++; $display("FAIL done_outputs: got st=%0d flags=%b expected st=5 flags=11001",
                         state, {match_done, win_led, lose_led, tie_led, stop_signal});
    end
    n_checks++;
    if ({player_score, computer_score} !== {4'd3, 4'd2}) begin
      n_fail++; $display("FAIL done_scores: got %h expected 32", {player_score, computer_score});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({state, player_score, computer_score, round_count, clear_choice, match_done,
         stop_signal, win_led} !== {3'd1, 14'd0, 4'b1000}) begin
      n_fail++; $display("FAIL restart: got st=%0d sc=%h clr=%b done=%b stop=%b win=%b",
                         state, {player_score, computer_score, round_count}, clear_choice,
                         match_done, stop_signal, win_led);
    end
  endtask

  task automatic test_tie();
    logic [2:0] leds, st; logic [13:0] sc; int len; logic clr, stp;
    run_round(2'b11, 2'b11, 1'b0, leds, sc, len, st, clr, stp);
    n_checks++;
    if ({leds, sc} !== {3'b001, 4'd0, 4'd0, 6'd1}) begin
      n_fail++; $display("FAIL tie_round: got leds=%b sc=%h expected leds=001 sc=001", leds, sc);
    end
    run_round(2'b01, 2'b00, 1'b1, leds, sc, len, st, clr, stp);
    n_checks++;
    if ({leds, sc, st} !== {3'b001, 4'd0, 4'd0, 6'd2, 3'd1}) begin
      n_fail++; $display("FAIL void_round: got leds=%b sc=%h st=%0d expected leds=001 sc=002 st=1",
                         leds, sc, st);
    end
  endtask

  task automatic test_invalid_confirm();
    player_choice = 2'b00; computer_choice = 2'b10; confirm = 1'b1;
    repeat (INV_HOLD) tick();
    n_checks++;
    if ({state, stop_signal} !== {3'd1, 1'b0}) begin
      n_fail++; $display("FAIL unset_confirm: got st=%0d stop=%b expected st=1 stop=0",
                         state, stop_signal);
    end
    confirm = 1'b0;
  endtask

  task automatic test_show_start_and_reset();
    player_choice = 2'b10; computer_choice = 2'b01; player_win = 1'b1; confirm = 1'b1;
    tick();
    confirm = 1'b0;
    tick(); tick();
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    n_checks++;
    if ({state, player_score, round_count} !== {3'd4, 4'd1, 6'd3}) begin
      n_fail++; $display("FAIL start_in_show: got st=%0d ps=%0d rc=%0d expected st=4 ps=1 rc=3",
                         state, player_score, round_count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (all_outs() !== 24'h0) begin
      n_fail++; $display("FAIL async_reset: got %h expected %h", all_outs(), 24'h0);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

`ifdef RPS_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (state != 3'd3 && n < 50) begin
      n++;
      tick();
    end
    n_checks++;
    if (n !== 9) begin
      n_fail++; $display("FAIL timeout_latency: got %0d expected 9", n);
    end
    tick();
    n_checks++;
    if ({lose_led, computer_score, timeout_flag} !== {1'b1, 4'd1, 1'b1}) begin
      n_fail++; $display("FAIL timeout_forfeit: got lose=%b cs=%0d to=%b expected 1 1 1",
                         lose_led, computer_score, timeout_flag);
    end
    n = 0;
    while (state != 3'd1 && n < 50) begin
      n++;
      tick();
    end
    repeat (7) tick();
    player_choice = 2'b10; computer_choice = 2'b01; player_win = 1'b1; confirm = 1'b1;
    tick();
    confirm = 1'b0;
    tick(); tick();
    n_checks++;
    if ({state, win_led, player_score, timeout_flag} !== {3'd4, 1'b1, 4'd1, 1'b0}) begin
      n_fail++; $display("FAIL expiry_confirm: got st=%0d win=%b ps=%0d to=%b expected 4 1 1 0",
                         state, win_led, player_score, timeout_flag);
    end
  endtask
`else
  task automatic test_no_timeout();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (1000) tick();
    n_checks++;
    if ({state, timeout_flag} !== {3'd1, 1'b0}) begin
      n_fail++; $display("FAIL no_timeout: got st=%0d to=%b expected st=1 to=0",
                         state, timeout_flag);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_first_round();
    test_match();
    test_tie();
    test_invalid_confirm();
    test_show_start_and_reset();
`ifdef RPS_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
